fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage with its IF/ID pipeline register. It holds the program counter, drives the instruction-memory address and captures the fetched word with its PC for the decode stage. It feeds decode, which produces `reg_data`, `imm`, `rs1`, `rs2`, `rd` and `control` for the ID/EX register. It applies stall and branch redirect/flush, and it freezes fetch after a halt instruction.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard-unit load-use stall; hold PC and IF/ID.
- `redirect` in 1: taken branch or jump resolved downstream.
- `br_target` in 64: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_addr` out 64: instruction-memory address, equal to the PC register.
- `imem_data` in 32: instruction word, combinational read of `imem_addr`.
- `PC_out` out 64: IF/ID PC.
- `instr_out` out 32: IF/ID instruction.
- `valid_out` out 1: IF/ID holds a real instruction.
- `halted` out 1: fetch is frozen by HLT.
- `fetch_count` out 32: number of valid instructions delivered into IF/ID.

## Operation
- State machine, two states: RUN and HALTED.
- Reset values:
  - PC = RESET_PC.
  - `PC_out` = 0, `instr_out` = NOP (32'hD503201F), `valid_out` = 0.
  - `halted` = 0, `fetch_count` = 0, state = RUN.
- Priority each cycle: reset > redirect > stall > normal.
- RUN, normal (no stall, no redirect):
  - IF/ID <= {PC, `imem_data`, 1}; PC <= PC+4; `fetch_count` +1.
  - If `imem_data` == HLT (32'hD4400000), the HLT is still delivered (valid 1), the PC is not advanced, and the next state is HALTED.
- RUN, stall without redirect: PC, IF/ID and `fetch_count` hold.
- Redirect, in any state, with or without stall:
  - PC <= {`br_target`[63:2], 2'b00}.
  - IF/ID <= bubble: `PC_out` = 0, `instr_out` = NOP, `valid_out` = 0.
  - State <= RUN, `halted` <= 0, and `fetch_count` is unchanged.
  - This covers an HLT that was fetched on a wrong path.
- HALTED, no redirect:
  - PC holds.
  - IF/ID <= bubble on the first HALTED cycle and every cycle after, unless stall holds it.
  - `halted` = 1.
- Arithmetic: PC+4 wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC → 0). `fetch_count` wraps modulo 2^32.
- `halted` is a registered output that mirrors the state.

## Timing
- `imem_addr` equals the PC register with no combinational path from any input.
- Fetch latency: the word addressed in cycle n appears on `instr_out`/`PC_out` in cycle n+1.
- Redirect asserted in cycle n:
  - Target on `imem_addr` in n+1.
  - Bubble in IF/ID in n+1.
  - Target instruction in IF/ID in n+2, so 1 bubble of penalty.
- A stall lasting k cycles delays every subsequent IF/ID update by exactly k cycles and duplicates nothing.
- Reset asserted mid-stream: all outputs take their reset values at the next edge. The first valid instruction (from RESET_PC) appears one cycle after the first non-reset edge.
- HLT fetched in cycle n: `halted` = 1 from cycle n+1, with the HLT in IF/ID in n+1.

## Structure
- Shared package `cpu_pkg`:
  - `NOP_INSTR` (32'hD503201F) and `HLT_INSTR` (32'hD4400000).
  - `fetch_state_t` enum {RUN, HALTED}.
  - `INSTR_W` = 32.
- PC storage reuses the existing `reg64` sub-module, with its enable driven from the next-PC logic.
- The IF/ID register is built from `reg64` for the PC and `D_FF` bits for the instruction and valid bit.
- Next-PC mux and counter are in-module.

## Test plan
- Reset, RESET_PC=64'h100, memory holding sequential words A,B,C → `imem_addr` 0x100,0x104,0x108 on consecutive cycles; IF/ID {0x100,A,1}, {0x104,B,1}, …; `fetch_count` 1,2,3.
- Stall held 2 cycles while PC=0x108 → `imem_addr` stays 0x108 for 3 cycles; IF/ID holds {0x104,B,1}; `fetch_count` is unchanged; C follows with no duplicate.
- Redirect to 64'h2003 together with stall, at PC=0x10C → next cycle `imem_addr`=0x2000 and IF/ID a bubble (valid 0, NOP); the cycle after, IF/ID = {0x2000, mem[0x2000], 1}.
- HLT at 0x110 → IF/ID {0x110,HLT,1}; `halted`=1 thereafter; `imem_addr` stuck at 0x110; bubbles follow for 5+ cycles. A redirect to 0x300 then clears `halted` and resumes fetch at 0x300.
- PC wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → second fetch address is 0.
- Reset asserted during a redirect cycle → PC=RESET_PC, `valid_out`=0, `fetch_count`=0 at the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction encodings, fetch FSM states and widths.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;
  localparam logic [INSTR_W-1:0] HLT_INSTR = 32'hD4400000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/D_FF.sv
// Single-bit flip-flop with load enable and synchronous active-high reset to RST_VAL.
module D_FF #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg64.sv
// 64-bit register with load enable and synchronous active-high reset to RST_VAL.
module reg64 #(
  parameter logic [63:0] RST_VAL = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [63:0] d,
  output logic [63:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// halt freeze and delivered-instruction counter.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [63:0]        br_target,
  output logic [63:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [63:0]        PC_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
  output logic               halted,
  output logic [31:0]        fetch_count,
  output fetch_state_t       fsm_state
);

  // Control priority: reset > redirect > stall > normal fetch. A redirect always
  // squashes IF/ID to a bubble and wins over both stall and halt.

  fetch_state_t       state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic               pc_en;
  logic               ifid_en;
  logic [63:0]        ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic               ifid_valid_d;
  logic               cnt_inc;
  logic [63:0]        redirect_pc;

  wire unused_br_lsb = &{1'b0, br_target[1:0]};

  assign redirect_pc = {br_target[63:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    pc_d         = pc_q;
    ifid_en      = 1'b0;
    ifid_pc_d    = 64'h0;
    ifid_instr_d = NOP_INSTR;
    ifid_valid_d = 1'b0;
    cnt_inc      = 1'b0;
    if (redirect) begin
      state_d = RUN;
      pc_en   = 1'b1;
      pc_d    = redirect_pc;
      ifid_en = 1'b1;
    end else if (stall) begin
      // hold everything
    end else if (state_q == RUN) begin
      ifid_en      = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_data;
      ifid_valid_d = 1'b1;
      cnt_inc      = 1'b1;
      if (imem_data == HLT_INSTR) begin
        // HLT is delivered but the PC parks on it
        state_d = HALTED;
      end else begin
        pc_en = 1'b1;
        pc_d  = pc_q + 64'd4;
      end
    end else begin
      ifid_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'd0;
    end else if (cnt_inc) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  reg64 #(.RST_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  reg64 #(.RST_VAL(64'h0)) u_ifid_pc (
    .clk   (clk),
    .reset (reset),
    .en    (ifid_en),
    .d     (ifid_pc_d),
    .q     (PC_out)
  );

  for (genvar i = 0; i < INSTR_W; i++) begin : g_ifid_instr
    D_FF #(.RST_VAL(NOP_INSTR[i])) u_bit (
      .clk   (clk),
      .reset (reset),
      .en    (ifid_en),
      .d     (ifid_instr_d[i]),
      .q     (instr_out[i])
    );
  end

  D_FF #(.RST_VAL(1'b0)) u_ifid_valid (
    .clk   (clk),
    .reset (reset),
    .en    (ifid_en),
    .d     (ifid_valid_d),
    .q     (valid_out)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALTED);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, halt, PC wrap
// and reset during redirect, with hand-computed expectations.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         reset, stall, redirect;
  logic [63:0]  br_target;
  logic [63:0]  imem_addr;
  logic [31:0]  imem_data;
  logic [63:0]  pc_out;
  logic [31:0]  instr_out;
  logic         valid_out, halted;
  logic [31:0]  fetch_count;
  fetch_state_t fsm_state;

  logic         reset2;
  logic [63:0]  imem_addr2, pc_out2;
  logic [31:0]  imem_data2, instr_out2, fetch_count2;
  logic         valid_out2, halted2;
  fetch_state_t fsm_state2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Memory image: HLT at 0x110, every other word tagged with its address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h110) return HLT_INSTR;
    return {8'hE0, a[23:0]};
  endfunction

  always_comb imem_data  = mem_word(imem_addr);
  always_comb imem_data2 = mem_word(imem_addr2);

  fetch_stage #(.RESET_PC(64'h100)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .PC_out      (pc_out),
    .instr_out   (instr_out),
    .valid_out   (valid_out),
    .halted      (halted),
    .fetch_count (fetch_count),
    .fsm_state   (fsm_state)
  );

  fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .reset       (reset2),
    .stall       (1'b0),
    .redirect    (1'b0),
    .br_target   (64'h0),
    .imem_addr   (imem_addr2),
    .imem_data   (imem_data2),
    .PC_out      (pc_out2),
    .instr_out   (instr_out2),
    .valid_out   (valid_out2),
    .halted      (halted2),
    .fetch_count (fetch_count2),
    .fsm_state   (fsm_state2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc,
                            input logic [31:0] ins, input logic v);
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".instr"}, {32'h0, instr_out}, {32'h0, ins});
    check({tag, ".valid"}, {63'h0, valid_out}, {63'h0, v});
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; stall = 1'b0; redirect = 1'b0; br_target = 64'h0;
    step(); step();
    check("rst.addr", imem_addr, 64'h100);
    check_ifid("rst", 64'h0, NOP_INSTR, 1'b0);
    check("rst.cnt", {32'h0, fetch_count}, 64'd0);
    check("rst.halted", {63'h0, halted}, 64'd0);
    check("wrap.rst_addr", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);

    // sequential fetch A, B
    reset = 1'b0; reset2 = 1'b0;
    step();
    check_ifid("seqA", 64'h100, 32'hE000_0100, 1'b1);
    check("seqA.addr", imem_addr, 64'h104);
    check("seqA.cnt", {32'h0, fetch_count}, 64'd1);
    check("wrap.addr", imem_addr2, 64'h0);
    check_ifid_wrap: begin
      check("wrap.pc", pc_out2, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap.valid", {63'h0, valid_out2}, 64'd1);
    end
    step();
    check_ifid("seqB", 64'h104, 32'hE000_0104, 1'b1);
    check("seqB.addr", imem_addr, 64'h108);
    check("seqB.cnt", {32'h0, fetch_count}, 64'd2);
    check("wrap.addr2", imem_addr2, 64'h4);

    // two-cycle stall at PC 0x108
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall.addr", imem_addr, 64'h108);
      check_ifid("stall", 64'h104, 32'hE000_0104, 1'b1);
      check("stall.cnt", {32'h0, fetch_count}, 64'd2);
    end
    stall = 1'b0;
    step();
    check_ifid("seqC", 64'h108, 32'hE000_0108, 1'b1);
    check("seqC.addr", imem_addr, 64'h10C);
    check("seqC.cnt", {32'h0, fetch_count}, 64'd3);

    // redirect with stall, low target bits dropped
    redirect = 1'b1; stall = 1'b1; br_target = 64'h2003;
    step();
    check("redir.addr", imem_addr, 64'h2000);
    check_ifid("redir", 64'h0, NOP_INSTR, 1'b0);
    check("redir.cnt", {32'h0, fetch_count}, 64'd3);
    redirect = 1'b0; stall = 1'b0;
    step();
    check_ifid("tgt", 64'h2000, 32'hE000_2000, 1'b1);
    check("tgt.addr", imem_addr, 64'h2004);
    check("tgt.cnt", {32'h0, fetch_count}, 64'd4);

    // jump onto the HLT at 0x110
    redirect = 1'b1; br_target = 64'h110;
    step();
    redirect = 1'b0;
    check_ifid("preh", 64'h0, NOP_INSTR, 1'b0);
    step();
    check_ifid("hlt", 64'h110, HLT_INSTR, 1'b1);
    check("hlt.halted", {63'h0, halted}, 64'd1);
    check("hlt.state", {63'h0, fsm_state}, {63'h0, HALTED});
    check("hlt.addr", imem_addr, 64'h110);
    check("hlt.cnt", {32'h0, fetch_count}, 64'd5);
    for (int i = 0; i < 5; i++) begin
      step();
      check_ifid("halt", 64'h0, NOP_INSTR, 1'b0);
      check("halt.addr", imem_addr, 64'h110);
      check("halt.halted", {63'h0, halted}, 64'd1);
      check("halt.cnt", {32'h0, fetch_count}, 64'd5);
    end

    // redirect out of HALTED
    redirect = 1'b1; br_target = 64'h300;
    step();
    redirect = 1'b0;
    check("resume.halted", {63'h0, halted}, 64'd0);
    check("resume.addr", imem_addr, 64'h300);
    check_ifid("resume", 64'h0, NOP_INSTR, 1'b0);
    step();
    check_ifid("r300", 64'h300, 32'hE000_0300, 1'b1);
    check("r300.cnt", {32'h0, fetch_count}, 64'd6);

    // reset coinciding with a redirect
    reset = 1'b1; redirect = 1'b1; br_target = 64'h500;
    step();
    check("rr.addr", imem_addr, 64'h100);
    check("rr.valid", {63'h0, valid_out}, 64'd0);
    check("rr.cnt", {32'h0, fetch_count}, 64'd0);
    reset = 1'b0; redirect = 1'b0;
    step();
    check_ifid("rrA", 64'h100, 32'hE000_0100, 1'b1);
    check("rrA.cnt", {32'h0, fetch_count}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
